// File: rtl/seven_seg_pkg.sv
// Segment patterns for the multiplexed 7-segment bus (bit 6 = a ... bit 0 = g),
// shared by the display driver and the reader.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_UNSTABLE,
    ST_CAPTURE,
    ST_HELD
  } reader_state_t;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational 7-segment pattern to hex nibble decoder; flags blank and legal codes.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic       o_legal,
  output logic       o_blank,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_legal  = 1'b1;
    o_nibble = 4'h0;
    o_blank  = (i_pattern == SEG_BLANK);
    case (i_pattern)
      SEG_0:   o_nibble = 4'h0;
      SEG_1:   o_nibble = 4'h1;
      SEG_2:   o_nibble = 4'h2;
      SEG_3:   o_nibble = 4'h3;
      SEG_4:   o_nibble = 4'h4;
      SEG_5:   o_nibble = 4'h5;
      SEG_6:   o_nibble = 4'h6;
      SEG_7:   o_nibble = 4'h7;
      SEG_8:   o_nibble = 4'h8;
      SEG_9:   o_nibble = 4'h9;
      SEG_A:   o_nibble = 4'hA;
      SEG_B:   o_nibble = 4'hB;
      SEG_C:   o_nibble = 4'hC;
      SEG_D:   o_nibble = 4'hD;
      SEG_E:   o_nibble = 4'hE;
      SEG_F:   o_nibble = 4'hF;
      default: o_legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Receive side of the multiplexed 7-segment bus: synchronizes the bus, waits for a
// stable pattern, decodes it and holds one nibble per digit.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16
)
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            abcdefg,
  input  logic [DIGITS-1:0]     digit_sel,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  update,
  output logic [2:0]            update_index,
  output logic                  error
);

  localparam int W  = 7 + DIGITS;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES - 2);

  logic [W-1:0]          r_sync1, r_sync2, r_prev;
  logic [CW-1:0]         r_cnt;
  reader_state_t         r_state, w_next;
  logic [4*DIGITS-1:0]   r_digits;
  logic [DIGITS-1:0]     r_valid;
  logic                  r_update, r_error;
  logic [2:0]            r_updateIndex;

  logic [6:0]            w_pattern;
  logic [DIGITS-1:0]     w_sel;
  logic                  w_same, w_captureNow, w_oneHot;
  logic                  w_legal, w_blank;
  logic [3:0]            w_nibble;
  logic [2:0]            w_idx;

  assign w_pattern    = r_sync2[6:0];
  assign w_sel        = r_sync2[W-1:7];
  assign w_same       = (r_sync2 == r_prev);
  assign w_oneHot     = $onehot(w_sel);
  // Capture fires on the edge that enters CAPTURE so the pulse and the digit update coincide.
  assign w_captureNow = (r_state == ST_UNSTABLE) && w_same && (r_cnt == CNT_FIRE);

  seven_seg_decode u_decode (
    .i_pattern (w_pattern),
    .o_legal   (w_legal),
    .o_blank   (w_blank),
    .o_nibble  (w_nibble)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_sel[i]) w_idx = 3'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= {digit_sel, abcdefg};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (!w_same) r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_UNSTABLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_UNSTABLE: if (w_captureNow) w_next = ST_CAPTURE;
      // A change seen during CAPTURE must not be lost by parking in HELD.
      ST_CAPTURE:  w_next = w_same ? ST_HELD : ST_UNSTABLE;
      ST_HELD:     if (!w_same) w_next = ST_UNSTABLE;
      default:     w_next = ST_UNSTABLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_digits      <= '0;
      r_valid       <= '0;
      r_update      <= 1'b0;
      r_error       <= 1'b0;
      r_updateIndex <= '0;
    end else begin
      r_update <= 1'b0;
      r_error  <= 1'b0;
      if (w_captureNow && w_oneHot) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (w_sel[i]) begin
            r_valid[i] <= w_legal;
            if (w_legal) r_digits[4*i +: 4] <= w_nibble;
          end
        end
        if (w_legal) begin
          r_update      <= 1'b1;
          r_updateIndex <= w_idx;
        end else if (!w_blank) begin
          r_error <= 1'b1;
        end
      end
    end
  end

  assign digits       = r_digits;
  assign digit_valid  = r_valid;
  assign update       = r_update;
  assign update_index = r_updateIndex;
  assign error        = r_error;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Scoreboard bench for seven_seg_reader: expected captures are queued when the bus
// is driven and matched against update/error pulses.
module tb_seven_seg_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  abcdefg;
  logic [3:0]  digit_sel;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        update;
  logic [2:0]  update_index;
  logic        error;

  typedef struct {
    bit       isErr;
    int       idx;
    logic [3:0] nib;
    int       cycle;
  } expect_t;

  expect_t     sbQueue[$];
  expect_t     monEvent;
  logic [15:0] modelDigits;
  logic [3:0]  modelValid;
  int          compareCount = 0;
  int          failCount = 0;
  int          cycleCount = 0;

  seven_seg_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clock        (clock),
    .reset        (reset),
    .abcdefg      (abcdefg),
    .digit_sel    (digit_sel),
    .digits       (digits),
    .digit_valid  (digit_valid),
    .update       (update),
    .update_index (update_index),
    .error        (error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cycleCount);
    end
  endtask

  // Reference decode straight from the legal-code table; -2 = blank, -1 = illegal.
  function automatic int decodeRef(input logic [6:0] p);
    case (p)
      7'h7E: return 0;  7'h30: return 1;  7'h6D: return 2;  7'h79: return 3;
      7'h33: return 4;  7'h5B: return 5;  7'h5F: return 6;  7'h70: return 7;
      7'h7F: return 8;  7'h7B: return 9;  7'h77: return 10; 7'h1F: return 11;
      7'h4E: return 12; 7'h3D: return 13; 7'h4F: return 14; 7'h47: return 15;
      7'h00: return -2;
      default: return -1;
    endcase
  endfunction

  // Drive at a falling edge and hold; a one-hot strobe held long enough yields a capture
  // whose pulse is seen STABLE+2 edges later.
  task automatic applyStimulus(input logic [3:0] sel, input logic [6:0] pat, input int hold);
    int code;
    int idx;
    expect_t e;
    digit_sel = sel;
    abcdefg   = pat;
    if (hold >= STABLE + 2 && $onehot(sel)) begin
      idx = 0;
      for (int i = 0; i < DIGITS; i++) if (sel[i]) idx = i;
      code = decodeRef(pat);
      if (code >= 0) begin
        modelDigits[4*idx +: 4] = code[3:0];
        modelValid[idx] = 1'b1;
        e.isErr = 1'b0; e.idx = idx; e.nib = code[3:0]; e.cycle = cycleCount + STABLE + 2;
        sbQueue.push_back(e);
      end else begin
        modelValid[idx] = 1'b0;
        if (code == -1) begin
          e.isErr = 1'b1; e.idx = idx; e.nib = 4'h0; e.cycle = cycleCount + STABLE + 2;
          sbQueue.push_back(e);
        end
      end
    end
    repeat (hold) @(negedge clock);
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_digits"}, digits, modelDigits);
    checkOutput({tag, "_valid"}, digit_valid, modelValid);
  endtask

  // Pulse monitor: every update/error pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && (update || error)) begin
      checkOutput("exclusive_pulse", {31'b0, update & error}, 32'd0);
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_pulse", sbQueue.size(), 32'd1);
      end else begin
        monEvent = sbQueue.pop_front();
        checkOutput("pulse_kind", {31'b0, error}, {31'b0, monEvent.isErr});
        checkOutput("pulse_cycle", cycleCount, monEvent.cycle);
        if (!monEvent.isErr) begin
          checkOutput("update_index", update_index, monEvent.idx);
          checkOutput("update_nibble", digits[4*monEvent.idx +: 4], monEvent.nib);
        end
      end
    end
  end

  logic [3:0] scanSel [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [6:0] scanPat [4] = '{7'h7E, 7'h30, 7'h77, 7'h47};

  initial begin
    reset       = 1'b1;
    abcdefg     = 7'h00;
    digit_sel   = 4'b0000;
    modelDigits = 16'h0;
    modelValid  = 4'h0;
    repeat (3) @(negedge clock);
    checkOutput("reset_digits", digits, 32'h0);
    checkOutput("reset_valid", digit_valid, 32'h0);
    checkOutput("reset_update", update, 32'h0);
    checkOutput("reset_error", error, 32'h0);
    checkOutput("reset_index", update_index, 32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    checkState("idle");

    $display("[TB] single digit 6D on digit 0");
    applyStimulus(4'b0001, 7'h6D, 40);
    checkState("single");

    $display("[TB] short 5B then 4F on digit 1");
    applyStimulus(4'b0010, 7'h5B, 10);
    applyStimulus(4'b0010, 7'h4F, 20);
    checkState("interrupted");

    $display("[TB] four digit scan");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(scanSel[i], scanPat[i], 20);
      applyStimulus(4'b0000, 7'h00, 3);
    end
    checkOutput("scan_digits", digits, 32'h0000FA10);
    checkOutput("scan_valid", digit_valid, 32'hF);

    $display("[TB] illegal then blank on digit 2");
    applyStimulus(4'b0100, 7'h01, 20);
    checkState("illegal");
    applyStimulus(4'b0100, 7'h00, 20);
    checkState("blank");

    $display("[TB] two strobes at once");
    applyStimulus(4'b0011, 7'h7F, 50);
    checkState("multi_strobe");

    $display("[TB] reset during stable 79 on digit 3");
    applyStimulus(4'b1000, 7'h79, 5);
    reset = 1'b1;
    modelDigits = 16'h0;
    modelValid  = 4'h0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    applyStimulus(4'b1000, 7'h79, 25);
    checkState("after_reset");
    checkOutput("digit3", digits[15:12], 32'h3);

    repeat (5) @(negedge clock);
    checkOutput("pending_events", sbQueue.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/seven_seg_reader.md
# seven_seg_reader

Receive end of the multiplexed 7-segment display bus. Samples an external segment bus (`abcdefg` plus one-hot digit strobes), waits until each digit's pattern is stable, decodes it back to a hex nibble and holds per-digit values for downstream logic. Used for self-test loopback of our display drivers and for reading displays driven by other boards through `pio`.

## Interface
- `DIGITS`, default 4: number of multiplexed digits, 1..8.
- `STABLE_CYCLES`, default 16: consecutive identical synchronized samples required before capture, 2..255.
- `clock` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `abcdefg` in 7: segment lines, active-high, bit 6 = a … bit 0 = g. Asynchronous to `clock`.
- `digit_sel` in DIGITS: digit strobes, active-high, one-hot. Asynchronous to `clock`.
- `digits` out 4*DIGITS: decoded nibbles; digit i at [4i+3:4i].
- `digit_valid` out DIGITS: bit i set when `digits[i]` holds a legal hex value.
- `update` out 1: one-cycle pulse, a digit was captured with a legal code.
- `update_index` out 3: digit index of the last capture; meaningful while `update` is high.
- `error` out 1: one-cycle pulse, captured pattern was not a legal code.

## Operation
- Two-flop synchronizer on all 7+DIGITS input bits; sample `s` = second-stage output.
- `prev` register holds the previous `s`; stability counter `cnt` (width ceil(log2(STABLE_CYCLES+1))) cleared when `s != prev`, else incremented, saturating at STABLE_CYCLES.
- FSM states:
  - UNSTABLE: `cnt` < STABLE_CYCLES-1; goes to CAPTURE when `s == prev` and `cnt == STABLE_CYCLES-2`.
  - CAPTURE: single cycle; performs the capture action, then HELD.
  - HELD: waits; any `s != prev` returns to UNSTABLE. Exactly one capture per stable period.
- Capture action, on strobe field of `s`:
  - Exactly one bit i set, legal pattern: `digits[i]` ← nibble, `digit_valid[i]` ← 1, `update` = 1, `update_index` = i.
  - One bit i set, pattern 7'h00 (blank): `digit_valid[i]` ← 0, `digits[i]` unchanged, no pulse.
  - One bit i set, any other illegal pattern: `digit_valid[i]` ← 0, `error` = 1.
  - Zero or multiple strobes (inter-digit blanking, glitch): no change, no pulse.
- Legal codes (hex pattern → nibble): 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9, 77→A, 1F→b, 4E→C, 3D→d, 4F→E, 47→F.
- Reset: `digits` = 0, `digit_valid` = 0, `update` = 0, `update_index` = 0, `error` = 0, synchronizer/`prev` = 0, `cnt` = 0, state UNSTABLE.

## Timing
- Inputs change before edge k and then hold: `s` reflects them after edge k+1; `update`/`error` high during the cycle after edge k+1+STABLE_CYCLES, low again after the next edge.
- `digits`/`digit_valid` change on the same edge that raises `update`.
- Input change during UNSTABLE or in the cycle CAPTURE is entered: counting restarts; no capture for the interrupted value.
- A value held indefinitely produces exactly one pulse.
- Reset mid-count or in CAPTURE: no pulse emitted; count restarts from 0 after reset release.
- `update` and `error` are never both high.

## Structure
- Package `seven_seg_pkg`: the 16 pattern constants and the blank constant, shared with the display driver.
- Sub-module `seven_seg_decode`: combinational 7-bit pattern → {legal, blank, nibble[3:0]}; instantiated once on the sampled pattern.
- Synchronizer, stability counter, FSM and digit registers live in `seven_seg_reader`.

## Test plan
- Reset, then strobe 4'b0001 with pattern 6D held 40 cycles (STABLE_CYCLES=16) → one `update`, index 0, `digits[3:0]` = 2, `digit_valid` = 4'b0001; pulse 18 cycles after input edge.
- Pattern 5B held only 10 cycles on digit 1, then 4F held → no capture for 5B; single `update` index 1, nibble E.
- Scan all four digits with 7E, 30, 77, 47, each held 20 cycles with 3 blank-strobe cycles between → `digits` = 16'hFA10, `digit_valid` = 4'b1111, four `update` pulses.
- Digit 2 pattern 01 (illegal) held 20 cycles → `error` pulse, `digit_valid[2]` = 0, `digits` unchanged; then 00 → no pulse, `digit_valid[2]` stays 0.
- Strobe 4'b0011 with pattern 7F held 50 cycles → no pulse, no register change.
- Assert `reset` 5 cycles into a stable 79 on digit 3, release, keep 79 held → no pulse before 18 cycles after release, then one `update` with `digits[15:12]` = 3.
